// File: rtl/core_mem_scheduler_if.sv
// Bundle of every requester, stall and memory-port signal around core_mem_scheduler.
// The slave modport is the scheduler's view; master is the core/memory side.
interface core_mem_scheduler_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_clk_en;
    logic          o_stall;

    logic          i_lsu_req;
    logic          i_fetch_req;
    logic          i_debug_req;
    logic          i_lsu_we;
    logic          i_debug_we;
    logic [AW-1:0] i_lsu_addr;
    logic [AW-1:0] i_fetch_addr;
    logic [AW-1:0] i_debug_addr;
    logic [3:0]    i_lsu_byte_en;
    logic [3:0]    i_debug_byte_en;
    logic [DW-1:0] i_lsu_wdata;
    logic [DW-1:0] i_debug_wdata;

    logic          o_lsu_gnt;
    logic          o_fetch_gnt;
    logic          o_debug_gnt;
    logic          o_lsu_ack;
    logic          o_fetch_ack;
    logic          o_debug_ack;
    logic [DW-1:0] o_lsu_rdata;
    logic [DW-1:0] o_fetch_rdata;
    logic [DW-1:0] o_debug_rdata;
    logic          o_err;

    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [3:0]    o_mem_byte_en;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;

    modport slave (
        input  i_clk_en,
        input  i_lsu_req, i_fetch_req, i_debug_req,
        input  i_lsu_we, i_debug_we,
        input  i_lsu_addr, i_fetch_addr, i_debug_addr,
        input  i_lsu_byte_en, i_debug_byte_en,
        input  i_lsu_wdata, i_debug_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_stall,
        output o_lsu_gnt, o_fetch_gnt, o_debug_gnt,
        output o_lsu_ack, o_fetch_ack, o_debug_ack,
        output o_lsu_rdata, o_fetch_rdata, o_debug_rdata,
        output o_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_byte_en, o_mem_wdata
    );

    modport master (
        output i_clk_en,
        output i_lsu_req, i_fetch_req, i_debug_req,
        output i_lsu_we, i_debug_we,
        output i_lsu_addr, i_fetch_addr, i_debug_addr,
        output i_lsu_byte_en, i_debug_byte_en,
        output i_lsu_wdata, i_debug_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_stall,
        input  o_lsu_gnt, o_fetch_gnt, o_debug_gnt,
        input  o_lsu_ack, o_fetch_ack, o_debug_ack,
        input  o_lsu_rdata, o_fetch_rdata, o_debug_rdata,
        input  o_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_byte_en, o_mem_wdata
    );
endinterface

// File: rtl/core_mem_scheduler.sv
// Arbitrates LSU, fetch and debug onto one memory port with one outstanding
// transaction, fetch starvation protection and a hung-transaction timeout.
module core_mem_scheduler #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    core_mem_scheduler_if.slave  bus
);
    localparam int NREQ = 3;
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0] ID_LSU   = 2'd0;
    localparam logic [1:0] ID_FETCH = 2'd1;
    localparam logic [1:0] ID_DEBUG = 2'd2;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_reg;
    logic [1:0]    owner_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [3:0]    mem_be_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [3:0]    starve_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          err_reg;

    logic          en;
    logic          idle_en;
    logic          force_fetch;
    logic          lsu_gnt;
    logic          fetch_gnt;
    logic          debug_gnt;
    logic          any_gnt;
    logic          tmo_expire;
    logic          done;
    logic          abort;

    logic [1:0]    win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [3:0]    win_be;
    logic [DW-1:0] win_wdata;

    logic [NREQ-1:0] ack_vec;
    logic [DW-1:0]   rdata_vec [NREQ];

    assign en          = bus.i_clk_en;
    assign idle_en     = (state_reg == IDLE) && en;
    assign force_fetch = (starve_reg == 4'(STARVE_LIMIT)) && bus.i_fetch_req;

    assign lsu_gnt   = idle_en && bus.i_lsu_req && !force_fetch;
    assign fetch_gnt = idle_en && bus.i_fetch_req && (!bus.i_lsu_req || force_fetch);
    assign debug_gnt = idle_en && bus.i_debug_req && !bus.i_lsu_req && !bus.i_fetch_req;
    assign any_gnt   = lsu_gnt || fetch_gnt || debug_gnt;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            assign tmo_expire = (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_tmo
            assign tmo_expire = 1'b0;
        end
    endgenerate

    // A memory ack on the expiry edge takes precedence over the abort.
    assign done  = (state_reg == BUSY) && en && bus.i_mem_ack;
    assign abort = (state_reg == BUSY) && en && !bus.i_mem_ack && tmo_expire;

    always_comb begin
        win_id    = ID_LSU;
        win_we    = bus.i_lsu_we;
        win_addr  = bus.i_lsu_addr;
        win_be    = bus.i_lsu_byte_en;
        win_wdata = bus.i_lsu_wdata;
        if (fetch_gnt) begin
            win_id    = ID_FETCH;
            win_we    = 1'b0;
            win_addr  = bus.i_fetch_addr;
            win_be    = 4'hF;
            win_wdata = '0;
        end else if (debug_gnt) begin
            win_id    = ID_DEBUG;
            win_we    = bus.i_debug_we;
            win_addr  = bus.i_debug_addr;
            win_be    = bus.i_debug_byte_en;
            win_wdata = bus.i_debug_wdata;
        end
        if (!win_we) begin
            win_be = 4'hF;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            owner_reg     <= ID_LSU;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
            starve_reg    <= '0;
            tmo_cnt_reg   <= '0;
            err_reg       <= 1'b0;
        end else if (en) begin
            err_reg <= abort;
            case (state_reg)
                IDLE: begin
                    if (any_gnt) begin
                        state_reg     <= BUSY;
                        owner_reg     <= win_id;
                        mem_we_reg    <= win_we;
                        mem_addr_reg  <= win_addr;
                        mem_be_reg    <= win_be;
                        mem_wdata_reg <= win_wdata;
                        tmo_cnt_reg   <= '0;
                        // Only LSU wins over a waiting fetch advance the count.
                        if (lsu_gnt && bus.i_fetch_req) begin
                            if (starve_reg != 4'(STARVE_LIMIT)) begin
                                starve_reg <= starve_reg + 4'd1;
                            end
                        end else begin
                            starve_reg <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.i_mem_ack || tmo_expire) begin
                        state_reg <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-requester completion pulse and read-data holding register.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic          ack_reg;
            logic [DW-1:0] rdata_reg;
            logic          mine;

            assign mine = (owner_reg == 2'(gi));

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else if (en) begin
                    ack_reg <= (done || abort) && mine;
                    if (mine && abort) begin
                        rdata_reg <= '0;
                    end else if (mine && done && !mem_we_reg) begin
                        rdata_reg <= bus.i_mem_rdata;
                    end
                end
            end

            assign ack_vec[gi]   = ack_reg;
            assign rdata_vec[gi] = rdata_reg;
        end
    endgenerate

    assign bus.o_lsu_gnt     = lsu_gnt;
    assign bus.o_fetch_gnt   = fetch_gnt;
    assign bus.o_debug_gnt   = debug_gnt;
    assign bus.o_lsu_ack     = ack_vec[ID_LSU];
    assign bus.o_fetch_ack   = ack_vec[ID_FETCH];
    assign bus.o_debug_ack   = ack_vec[ID_DEBUG];
    assign bus.o_lsu_rdata   = rdata_vec[ID_LSU];
    assign bus.o_fetch_rdata = rdata_vec[ID_FETCH];
    assign bus.o_debug_rdata = rdata_vec[ID_DEBUG];
    assign bus.o_err         = err_reg;

    assign bus.o_mem_req     = (state_reg == BUSY);
    assign bus.o_mem_we      = mem_we_reg;
    assign bus.o_mem_addr    = mem_addr_reg;
    assign bus.o_mem_byte_en = mem_be_reg;
    assign bus.o_mem_wdata   = mem_wdata_reg;

    // Debug traffic deliberately never stalls the pipeline.
    assign bus.o_stall = (state_reg == BUSY)
                       || (bus.i_lsu_req && !lsu_gnt)
                       || (bus.i_fetch_req && !fetch_gnt);
endmodule

// File: tb/tb_core_mem_scheduler.sv
// Directed bench for core_mem_scheduler: fetch/LSU/debug traffic, starvation,
// timeout, mid-transaction reset and clock-enable freezing.
module tb_core_mem_scheduler;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    core_mem_scheduler_if #(.AW(32), .DW(32)) bus ();

    core_mem_scheduler #(
        .AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        string order;
        string tag;
        logic  lsu_prev;
        n_cmp = 0;
        n_err = 0;
        order = "LLLLFLLLLF";

        rst = 1'b1;
        bus.i_clk_en = 1'b1;
        bus.i_lsu_req = 1'b0;   bus.i_fetch_req = 1'b0;  bus.i_debug_req = 1'b0;
        bus.i_lsu_we = 1'b0;    bus.i_debug_we = 1'b0;
        bus.i_lsu_addr = '0;    bus.i_fetch_addr = '0;   bus.i_debug_addr = '0;
        bus.i_lsu_byte_en = '0; bus.i_debug_byte_en = '0;
        bus.i_lsu_wdata = '0;   bus.i_debug_wdata = '0;
        bus.i_mem_ack = 1'b0;   bus.i_mem_rdata = '0;

        // Reset state
        tick();
        tick();
        chk("rst_mem_req", bus.o_mem_req, 1'b0);
        chk("rst_stall", bus.o_stall, 1'b0);
        chk("rst_acks", {bus.o_lsu_ack, bus.o_fetch_ack, bus.o_debug_ack, bus.o_err}, 4'b0000);
        chk("rst_addr", bus.o_mem_addr, 32'h0);
        rst = 1'b0;
        tick();

        // Fetch read of 0x100, memory acks on the second BUSY cycle
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h100;
        settle();
        chk("t1_fetch_gnt", bus.o_fetch_gnt, 1'b1);
        chk("t1_lsu_gnt", bus.o_lsu_gnt, 1'b0);
        chk("t1_stall_c0", bus.o_stall, 1'b0);
        tick();
        bus.i_fetch_req = 1'b0;
        settle();
        chk("t1_mem_req_c1", bus.o_mem_req, 1'b1);
        chk("t1_addr", bus.o_mem_addr, 32'h100);
        chk("t1_we_be", {bus.o_mem_we, bus.o_mem_byte_en}, 5'b0_1111);
        chk("t1_stall_c1", bus.o_stall, 1'b1);
        tick();
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h13;
        settle();
        chk("t1_mem_req_c2", bus.o_mem_req, 1'b1);
        chk("t1_stall_c2", bus.o_stall, 1'b1);
        tick();
        bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
        settle();
        chk("t1_fetch_ack", bus.o_fetch_ack, 1'b1);
        chk("t1_fetch_rdata", bus.o_fetch_rdata, 32'h13);
        chk("t1_mem_req_c3", bus.o_mem_req, 1'b0);
        chk("t1_err", bus.o_err, 1'b0);
        chk("t1_stall_c3", bus.o_stall, 1'b0);
        $display("txn fetch rd 0x100 rdata=%0h", bus.o_fetch_rdata);
        tick();
        chk("t1_ack_one_cycle", bus.o_fetch_ack, 1'b0);

        // LSU write against a competing fetch
        bus.i_lsu_req = 1'b1; bus.i_lsu_we = 1'b1; bus.i_lsu_addr = 32'h1000;
        bus.i_lsu_wdata = 32'hAABBCCDD; bus.i_lsu_byte_en = 4'h3;
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h200;
        settle();
        chk("t2_lsu_gnt", bus.o_lsu_gnt, 1'b1);
        chk("t2_fetch_gnt", bus.o_fetch_gnt, 1'b0);
        chk("t2_stall", bus.o_stall, 1'b1);
        tick();
        bus.i_lsu_req = 1'b0;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hDEADBEEF;
        settle();
        chk("t2_we", bus.o_mem_we, 1'b1);
        chk("t2_addr", bus.o_mem_addr, 32'h1000);
        chk("t2_be", bus.o_mem_byte_en, 4'h3);
        chk("t2_wdata", bus.o_mem_wdata, 32'hAABBCCDD);
        chk("t2_fetch_gnt_busy", bus.o_fetch_gnt, 1'b0);
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("t2_lsu_ack", bus.o_lsu_ack, 1'b1);
        chk("t2_lsu_rdata_hold", bus.o_lsu_rdata, 32'h0);
        chk("t2_fetch_gnt_after", bus.o_fetch_gnt, 1'b1);
        $display("txn lsu wr 0x1000 data=aabbccdd be=3");
        tick();
        bus.i_fetch_req = 1'b0;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h55;
        settle();
        chk("t2_fetch_addr", bus.o_mem_addr, 32'h200);
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("t2_fetch_ack", {bus.o_fetch_ack, bus.o_lsu_ack}, 2'b10);
        chk("t2_fetch_rdata", bus.o_fetch_rdata, 32'h55);
        $display("txn fetch rd 0x200 rdata=%0h", bus.o_fetch_rdata);

        // Continuous LSU + fetch contention with a 1-cycle memory
        bus.i_lsu_req = 1'b1; bus.i_lsu_we = 1'b0; bus.i_lsu_addr = 32'h2000;
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h300;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h66;
        lsu_prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            tag = $sformatf("t3_gnt%0d", i);
            chk(tag, {bus.o_lsu_gnt, bus.o_fetch_gnt}, (order[i] == "L") ? 2'b10 : 2'b01);
            if (i > 0) begin
                tag = $sformatf("t3_ack%0d", i);
                chk(tag, {bus.o_lsu_ack, bus.o_fetch_ack}, lsu_prev ? 2'b10 : 2'b01);
            end
            lsu_prev = (order[i] == "L");
            $display("txn contention grant %0d -> %s", i, (order[i] == "L") ? "lsu" : "fetch");
            tick();
            tick();
        end
        bus.i_lsu_req = 1'b0; bus.i_fetch_req = 1'b0; bus.i_mem_ack = 1'b0;
        settle();
        chk("t3_last_ack", {bus.o_lsu_ack, bus.o_fetch_ack}, 2'b01);
        chk("t3_no_gnt", {bus.o_lsu_gnt, bus.o_fetch_gnt, bus.o_debug_gnt}, 3'b000);
        tick();

        // Debug read completing normally
        bus.i_debug_req = 1'b1; bus.i_debug_we = 1'b0; bus.i_debug_addr = 32'h400;
        bus.i_debug_byte_en = 4'h1;
        settle();
        chk("t4_debug_gnt", bus.o_debug_gnt, 1'b1);
        chk("t4_debug_nostall", bus.o_stall, 1'b0);
        tick();
        bus.i_debug_req = 1'b0;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hCAFE;
        settle();
        chk("t4_debug_be", bus.o_mem_byte_en, 4'hF);
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("t4_debug_ack", {bus.o_debug_ack, bus.o_err}, 2'b10);
        chk("t4_debug_rdata", bus.o_debug_rdata, 32'hCAFE);
        $display("txn debug rd 0x400 rdata=%0h", bus.o_debug_rdata);
        tick();

        // Debug read that never gets an ack: 8 BUSY cycles then error
        bus.i_debug_req = 1'b1; bus.i_debug_addr = 32'h404;
        settle();
        chk("t5_debug_gnt", bus.o_debug_gnt, 1'b1);
        tick();
        bus.i_debug_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            settle();
            tag = $sformatf("t5_mem_req_c%0d", k);
            chk(tag, bus.o_mem_req, 1'b1);
            tick();
        end
        settle();
        chk("t5_mem_req_drop", bus.o_mem_req, 1'b0);
        chk("t5_err_ack", {bus.o_debug_ack, bus.o_err}, 2'b11);
        chk("t5_rdata_zero", bus.o_debug_rdata, 32'h0);
        chk("t5_other_acks", {bus.o_lsu_ack, bus.o_fetch_ack}, 2'b00);
        $display("txn debug rd 0x404 timed out err=%0b", bus.o_err);
        tick();
        chk("t5_err_one_cycle", {bus.o_debug_ack, bus.o_err}, 2'b00);

        // Ack arriving on the expiry edge completes normally
        bus.i_lsu_req = 1'b1; bus.i_lsu_we = 1'b0; bus.i_lsu_addr = 32'h500;
        settle();
        chk("t6_lsu_gnt", bus.o_lsu_gnt, 1'b1);
        tick();
        bus.i_lsu_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bus.i_mem_ack = (k == 8);
            bus.i_mem_rdata = 32'h99;
            tick();
        end
        bus.i_mem_ack = 1'b0;
        settle();
        chk("t6_race_ack", {bus.o_lsu_ack, bus.o_err}, 2'b10);
        chk("t6_race_rdata", bus.o_lsu_rdata, 32'h99);
        $display("txn lsu rd 0x500 ack on expiry edge rdata=%0h", bus.o_lsu_rdata);
        tick();

        // Reset asserted mid-transaction with an ack pending
        bus.i_lsu_req = 1'b1; bus.i_lsu_addr = 32'h40; bus.i_lsu_byte_en = 4'h3;
        settle();
        chk("t7_lsu_gnt", bus.o_lsu_gnt, 1'b1);
        tick();
        bus.i_lsu_req = 1'b0;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h1234;
        settle();
        chk("t7_busy", bus.o_mem_req, 1'b1);
        chk("t7_read_be", bus.o_mem_byte_en, 4'hF);
        rst = 1'b1;
        settle();
        chk("t7_rst_mem_req", bus.o_mem_req, 1'b0);
        tick();
        bus.i_mem_ack = 1'b0;
        rst = 1'b0;
        settle();
        chk("t7_no_ack", {bus.o_lsu_ack, bus.o_err}, 2'b00);
        chk("t7_rdata_cleared", bus.o_lsu_rdata, 32'h0);
        $display("txn lsu rd 0x40 abandoned by reset");
        tick();
        bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 32'h600;
        settle();
        chk("t7_regrant", bus.o_fetch_gnt, 1'b1);
        tick();
        bus.i_fetch_req = 1'b0;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h77AA;
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("t7_regrant_ack", bus.o_fetch_ack, 1'b1);
        chk("t7_regrant_rdata", bus.o_fetch_rdata, 32'h77AA);
        $display("txn fetch rd 0x600 rdata=%0h", bus.o_fetch_rdata);
        tick();

        // Clock enable low during BUSY with the memory ack asserted
        bus.i_lsu_req = 1'b1; bus.i_lsu_addr = 32'h80;
        settle();
        chk("t8_lsu_gnt", bus.o_lsu_gnt, 1'b1);
        tick();
        bus.i_lsu_req = 1'b0;
        bus.i_clk_en = 1'b0;
        bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            tag = $sformatf("t8_frozen%0d", k);
            chk(tag, {bus.o_mem_req, bus.o_lsu_ack}, 2'b10);
        end
        bus.i_clk_en = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        bus.i_clk_en = 1'b0;
        bus.i_lsu_req = 1'b1; bus.i_lsu_addr = 32'h84;
        settle();
        chk("t8_ack", {bus.o_lsu_ack, bus.o_mem_req}, 2'b10);
        chk("t8_rdata", bus.o_lsu_rdata, 32'h77);
        chk("t8_gnt_disabled", bus.o_lsu_gnt, 1'b0);
        chk("t8_stall_disabled", bus.o_stall, 1'b1);
        $display("txn lsu rd 0x80 rdata=%0h after enable gap", bus.o_lsu_rdata);
        tick();
        chk("t8_ack_stretched", bus.o_lsu_ack, 1'b1);
        bus.i_lsu_req = 1'b0;
        bus.i_clk_en = 1'b1;
        tick();
        chk("t8_ack_cleared", bus.o_lsu_ack, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
